// File: rtl/wd279x_pkg.sv
// rtl/wd279x_pkg.sv - shared states, mark constants and sector length helper for the field parser
package wd279x_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SYNC,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_CHECK1,
    ST_CHECK2
  } state_t;

  localparam logic [7:0]  MARK_A1    = 8'hA1;
  localparam logic [7:0]  MARK_ID    = 8'hFE;
  localparam logic [7:0]  MARK_DATA  = 8'hFB;
  localparam logic [7:0]  MARK_DDATA = 8'hF8;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;

  function automatic logic [10:0] sector_len(input logic [1:0] size_code);
    return 11'd128 << size_code;
  endfunction

endpackage

// File: rtl/wd279x_crc.sv
// rtl/wd279x_crc.sv - byte-wide MSB-first CRC; restarts while valid is low, latches result when valid falls
module wd279x_crc #(
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLYNOM   = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] INIT      = '1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid,
  input  logic                 we,
  input  logic [7:0]           data_in,
  output logic [CRC_WIDTH-1:0] crc
);

  logic [CRC_WIDTH-1:0] acc;
  logic                 valid_d;

  function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c_in,
                                                    input logic [7:0] d);
    logic [CRC_WIDTH-1:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[CRC_WIDTH-1] ^ d[i]) c = (c << 1) ^ POLYNOM;
      else                       c = c << 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc     <= INIT;
      crc     <= '0;
      valid_d <= 1'b0;
    end else begin
      valid_d <= valid;
      if (!valid) begin
        acc <= INIT;
        if (valid_d) crc <= acc;
      end else if (we) begin
        acc <= crc_byte(acc, data_in);
      end
    end
  end

endmodule

// File: rtl/wd279x_field_parser.sv
// rtl/wd279x_field_parser.sv - A1 sync / address-mark framer with ID and data field extraction and CRC check
// Optional target-ID comparator and id_match output when WD279X_ID_MATCH_EN is defined.
module wd279x_field_parser
  import wd279x_pkg::*;
#(
  parameter int SYNC_COUNT    = 3,
  parameter int MAX_SIZE_CODE = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_stb,
  input  logic       mark_stb,
  input  logic       search,
  input  logic       field_sel,
  input  logic [1:0] size_code,
`ifdef WD279X_ID_MATCH_EN
  input  logic [7:0] tgt_track,
  input  logic [7:0] tgt_sector,
  input  logic [7:0] tgt_side,
  input  logic       side_cmp,
  output logic       id_match,
`endif
  output logic [7:0] id_track,
  output logic [7:0] id_side,
  output logic [7:0] id_sector,
  output logic [7:0] id_size,
  output logic [7:0] data_out,
  output logic       data_stb,
  output logic       deleted,
  output logic       field_done,
  output logic       crc_err,
  output logic       busy
);

  localparam logic [3:0] SYNC_N = SYNC_COUNT[3:0];
  localparam logic [1:0] MAX_SC = MAX_SIZE_CODE[1:0];

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic [10:0] idx, last_idx;
  logic        is_data, hunt_armed, crc_err_q, crc_valid;
  logic [15:0] crc;
  logic [1:0]  size_eff;
  logic        is_a1_mark, hunt_start, mark_byte, id_mark_ok, data_mark_ok, crc_nz;

  assign size_eff     = (size_code > MAX_SC) ? MAX_SC : size_code;
  assign is_a1_mark   = byte_stb & mark_stb & (byte_in == MARK_A1);
  // First HUNT cycle is ignored so the CRC always sees valid low before a new sync run.
  assign hunt_start   = (state == ST_HUNT) & hunt_armed & is_a1_mark;
  assign mark_byte    = byte_stb & ~mark_stb & (cnt == SYNC_N);
  assign id_mark_ok   = ~field_sel & (byte_in == MARK_ID);
  assign data_mark_ok = field_sel & ((byte_in == MARK_DATA) | (byte_in == MARK_DDATA));
  assign crc_nz       = (crc != 16'h0000);
  assign crc_err      = (state == ST_CHECK2) ? crc_nz : crc_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d    = state;
    crc_valid  = hunt_start;
    field_done = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_SYNC, ST_PAYLOAD, ST_CRC_HI, ST_CRC_LO: crc_valid = 1'b1;
      ST_CHECK2:                                  field_done = 1'b1;
      default: ;
    endcase
    if (!search) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: if (hunt_start) state_d = ST_SYNC;
        ST_SYNC: begin
          if (byte_stb) begin
            if (cnt != SYNC_N) begin
              if (!is_a1_mark) state_d = ST_HUNT;
            end else if (mark_stb) begin
              if (byte_in != MARK_A1) state_d = ST_HUNT;
            end else if (id_mark_ok || data_mark_ok) begin
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_PAYLOAD: if (byte_stb && idx == last_idx) state_d = ST_CRC_HI;
        ST_CRC_HI:  if (byte_stb) state_d = ST_CRC_LO;
        ST_CRC_LO:  if (byte_stb) state_d = ST_CHECK1;
        ST_CHECK1:  state_d = ST_CHECK2;
        ST_CHECK2:  state_d = ST_HUNT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

`ifdef WD279X_ID_MATCH_EN
  logic id_match_q, id_cmp;
  assign id_cmp   = (id_track == tgt_track) & (id_sector == tgt_sector) &
                    (~side_cmp | (id_side == tgt_side)) & ~crc_nz;
  assign id_match = (state == ST_CHECK2 && !is_data) ? id_cmp : id_match_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                                              id_match_q <= 1'b0;
    else if (search && state == ST_SYNC && mark_byte && id_mark_ok) id_match_q <= 1'b0;
    else if (search && state == ST_CHECK2 && !is_data)         id_match_q <= id_cmp;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      last_idx   <= '0;
      is_data    <= 1'b0;
      hunt_armed <= 1'b0;
      crc_err_q  <= 1'b0;
      id_track   <= '0;
      id_side    <= '0;
      id_sector  <= '0;
      id_size    <= '0;
      data_out   <= '0;
      data_stb   <= 1'b0;
      deleted    <= 1'b0;
    end else begin
      hunt_armed <= (state == ST_HUNT);
      data_stb   <= 1'b0;
      if (!search) begin
        cnt <= '0;
      end else begin
        case (state)
          ST_HUNT: if (hunt_start) cnt <= 4'd1;
          ST_SYNC: begin
            if (is_a1_mark && cnt != SYNC_N) cnt <= cnt + 4'd1;
            if (mark_byte) begin
              idx     <= '0;
              is_data <= field_sel;
              if (data_mark_ok) begin
                last_idx <= sector_len(size_eff) - 11'd1;
                deleted  <= (byte_in == MARK_DDATA);
              end else begin
                last_idx <= 11'd3;
              end
            end
          end
          ST_PAYLOAD: begin
            if (byte_stb) begin
              idx <= idx + 11'd1;
              if (is_data) begin
                data_out <= byte_in;
                data_stb <= 1'b1;
              end else begin
                case (idx[1:0])
                  2'd0: id_track  <= byte_in;
                  2'd1: id_side   <= byte_in;
                  2'd2: id_sector <= byte_in;
                  2'd3: id_size   <= byte_in;
                endcase
              end
            end
          end
          ST_CHECK2: crc_err_q <= crc_nz;
          default: ;
        endcase
      end
    end
  end

  wd279x_crc #(
    .CRC_WIDTH(16),
    .POLYNOM  (16'h1021),
    .INIT     (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (crc_valid),
    .we     (byte_stb),
    .data_in(byte_in),
    .crc    (crc)
  );

endmodule

// File: tb/tb_wd279x_field_parser.sv
// tb/tb_wd279x_field_parser.sv - randomized self-checking bench for the field parser
module tb_wd279x_field_parser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_stb = 1'b0, mark_stb = 1'b0, search = 1'b0, field_sel = 1'b0;
  logic [1:0] size_code = '0;
  logic [7:0] id_track, id_side, id_sector, id_size, data_out;
  logic       data_stb, deleted, field_done, crc_err, busy;
`ifdef WD279X_ID_MATCH_EN
  logic [7:0] tgt_track = '0, tgt_sector = '0, tgt_side = '0;
  logic       side_cmp = 1'b0, id_match, got_id_match;
`endif

  wd279x_field_parser dut (
    .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_stb(byte_stb),
    .mark_stb(mark_stb), .search(search), .field_sel(field_sel), .size_code(size_code),
`ifdef WD279X_ID_MATCH_EN
    .tgt_track(tgt_track), .tgt_sector(tgt_sector), .tgt_side(tgt_side),
    .side_cmp(side_cmp), .id_match(id_match),
`endif
    .id_track(id_track), .id_side(id_side), .id_sector(id_sector), .id_size(id_size),
    .data_out(data_out), .data_stb(data_stb), .deleted(deleted),
    .field_done(field_done), .crc_err(crc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, stb_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic got_crc_err, got_deleted;
  logic [7:0] got_data[$];
  logic [7:0] pl[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_stb) got_data.push_back(data_out);
    if (field_done) begin
      done_cnt++;
      done_cyc    = cyc;
      got_crc_err = crc_err;
      got_deleted = deleted;
`ifdef WD279X_ID_MATCH_EN
      got_id_match = id_match;
`endif
    end
  end

  // CCITT CRC, preset all ones, processed one bit at a time from the MSB
  function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic m);
    @(negedge clk);
    byte_in = b; mark_stb = m; byte_stb = 1'b1; stb_cyc = cyc;
    @(negedge clk);
    byte_stb = 1'b0; mark_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_field(input logic [7:0] mark, input logic corrupt);
    logic [7:0]  f[$];
    logic [15:0] c;
    for (int i = 0; i < 3; i++) f.push_back(8'hA1);
    f.push_back(mark);
    foreach (pl[i]) f.push_back(pl[i]);
    c = model_crc(f);
    for (int i = 0; i < 3; i++) send_byte(8'hA1, 1'b1);
    send_byte(mark, 1'b0);
    foreach (pl[i]) send_byte(pl[i], 1'b0);
    send_byte(c[15:8], 1'b0);
    send_byte(corrupt ? (c[7:0] ^ 8'h01) : c[7:0], 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    search = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || field_done !== 1'b0 || data_stb !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl busy=%b done=%b stb=%b exp=0/0/0", busy, field_done, data_stb);
    end
    checks++;
    if ({id_track, id_side, id_sector, id_size, data_out, deleted, crc_err} !== '0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {id_track, id_side, id_sector, id_size, data_out, deleted, crc_err});
    end
    search = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    search = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL hunt_busy got=%b exp=1", busy); end
  endtask

  task automatic run_id(input string name, input logic corrupt, input logic [7:0] tr,
                        input logic [7:0] sd, input logic [7:0] sc, input logic [7:0] sz);
    int d0;
    d0 = done_cnt;
    field_sel = 1'b0;
    pl = {};
    pl.push_back(tr); pl.push_back(sd); pl.push_back(sc); pl.push_back(sz);
    send_field(8'hFE, corrupt);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt - d0); end
    checks++;
    if ({id_track, id_side, id_sector, id_size} !== {tr, sd, sc, sz}) begin
      errors++; $display("FAIL %s id got=%h exp=%h", name, {id_track, id_side, id_sector, id_size}, {tr, sd, sc, sz});
    end
    checks++;
    if (got_crc_err !== corrupt) begin errors++; $display("FAIL %s crc_err got=%b exp=%b", name, got_crc_err, corrupt); end
  endtask

  task automatic test_id_field();
    run_id("id_good", 1'b0, 8'h00, 8'h00, 8'h01, 8'h02);
    checks++;
    if (done_cyc - stb_cyc != 2) begin errors++; $display("FAIL done_latency got=%0d exp=2", done_cyc - stb_cyc); end
    run_id("id_bad", 1'b1, 8'h00, 8'h00, 8'h01, 8'h02);
  endtask

  task automatic test_random_id();
    for (int n = 0; n < 4; n++)
      run_id("id_rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_data(input string name, input logic [7:0] mark, input logic [1:0] sz,
                          input logic incr);
    int d0, q0, len, bad;
    d0 = done_cnt; q0 = got_data.size();
    field_sel = 1'b1; size_code = sz;
    len = 128 << sz;
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(incr ? 8'(i) : 8'($urandom));
    send_field(mark, 1'b0);
    checks++;
    if (got_data.size() - q0 != len) begin
      errors++; $display("FAIL %s data_count got=%0d exp=%0d", name, got_data.size() - q0, len);
    end else begin
      bad = -1;
      for (int i = 0; i < len; i++) if (bad < 0 && got_data[q0 + i] !== pl[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++; $display("FAIL %s data[%0d] got=%h exp=%h", name, bad, got_data[q0 + bad], pl[bad]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || got_crc_err !== 1'b0) begin
      errors++; $display("FAIL %s done/crc got=%0d/%b exp=1/0", name, done_cnt - d0, got_crc_err);
    end
    checks++;
    if (got_deleted !== (mark == 8'hF8)) begin
      errors++; $display("FAIL %s deleted got=%b exp=%b", name, got_deleted, mark == 8'hF8);
    end
  endtask

  task automatic test_data_field();
    run_data("data_fb", 8'hFB, 2'd0, 1'b1);
    run_data("data_f8", 8'hF8, 2'd0, 1'b0);
    run_data("data_sz1", 8'hFB, 2'd1, 1'b0);
  endtask

  task automatic test_false_sync();
    int d0;
    d0 = done_cnt;
    field_sel = 1'b0;
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'h4E, 1'b0);
    run_id("false_sync", 1'b0, 8'd40, 8'd1, 8'd9, 8'd2);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL false_sync_total got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0, q0;
    d0 = done_cnt; q0 = got_data.size();
    field_sel = 1'b1; size_code = 2'd0;
    for (int i = 0; i < 3; i++) send_byte(8'hA1, 1'b1);
    send_byte(8'hFB, 1'b0);
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    search = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 0 || got_data.size() - q0 != 50) begin
      errors++; $display("FAIL abort_counts done=%0d data=%0d exp=0/50", done_cnt - d0, got_data.size() - q0);
    end
    search = 1'b1;
    repeat (2) @(negedge clk);
    run_data("after_abort", 8'hFB, 2'd0, 1'b0);
  endtask

`ifdef WD279X_ID_MATCH_EN
  task automatic run_match(input string name, input logic [7:0] sd, input logic [7:0] tsec,
                           input logic [7:0] tsd, input logic scmp);
    logic exp;
    tgt_track = 8'd5; tgt_sector = tsec; tgt_side = tsd; side_cmp = scmp;
    run_id(name, 1'b0, 8'd5, sd, 8'h01, 8'h02);
    exp = (tsec == 8'h01) && (!scmp || sd == tsd);
    checks++;
    if (got_id_match !== exp) begin errors++; $display("FAIL %s id_match got=%b exp=%b", name, got_id_match, exp); end
  endtask

  task automatic test_id_match();
    run_match("match_hit", 8'd0, 8'h01, 8'd0, 1'b1);
    run_match("match_miss", 8'd0, 8'h03, 8'd0, 1'b1);
    run_match("match_noside", 8'd1, 8'h01, 8'd0, 1'b0);
    run_match("match_side", 8'd1, 8'h01, 8'd0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_id_field();
    test_random_id();
    test_data_field();
    test_false_sync();
    test_abort();
`ifdef WD279X_ID_MATCH_EN
    test_id_match();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
